// File: rtl/fabric_switch_buffered_if.sv
// Token handshake bundle for fabric_switch_buffered.
// The master offers input tokens and accepts output heads; the switch is the slave.
interface fabric_switch_buffered_if #(
    parameter int NUM_INPUTS    = 4,
    parameter int NUM_OUTPUTS   = 4,
    parameter int PAYLOAD_WIDTH = 32
);
    logic [NUM_INPUTS-1:0]                     in_valid;
    logic [NUM_INPUTS-1:0]                     in_ready;
    logic [NUM_INPUTS-1:0][PAYLOAD_WIDTH-1:0]  in_data;
    logic [NUM_OUTPUTS-1:0]                    out_valid;
    logic [NUM_OUTPUTS-1:0]                    out_ready;
    logic [NUM_OUTPUTS-1:0][PAYLOAD_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fabric_switch_buffered.sv
// Buffered fabric switch: compressed route table, per-output FIFOs,
// round-robin merge and non-atomic broadcast with sticky error reporting.
module fabric_switch_buffered #(
    parameter int NUM_INPUTS = 4,
    parameter int NUM_OUTPUTS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH = 0,
    parameter logic [NUM_OUTPUTS*NUM_INPUTS-1:0] CONNECTIVITY = '1,
    parameter int FIFO_DEPTH = 2,
    parameter bit ALLOW_MERGE = 1'b0,
    localparam int PAYLOAD_WIDTH = DATA_WIDTH + TAG_WIDTH,
    localparam int NUM_CONNECTED = $countones(CONNECTIVITY)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    fabric_switch_buffered_if.slave  bus,
    input  logic [NUM_CONNECTED-1:0] cfg_route_table,
    output logic                     error_valid,
    output logic [15:0]              error_code
);

    localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [15:0] CFG_MIX_CODE = 16'd1;
    localparam logic [15:0] RT_UNROUTED_CODE = 16'd262;

    function automatic int conn_before(int pos);
        int n;
        n = 0;
        for (int p = 0; p < pos; p++) begin
            n += int'(CONNECTIVITY[p]);
        end
        return n;
    endfunction

    function automatic logic [NUM_INPUTS-1:0] col_mask();
        logic [NUM_INPUTS-1:0] m;
        m = '0;
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (CONNECTIVITY[o*NUM_INPUTS+i]) m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic [NUM_OUTPUTS-1:0] row_mask();
        logic [NUM_OUTPUTS-1:0] m;
        m = '0;
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (CONNECTIVITY[o*NUM_INPUTS+i]) m[o] = 1'b1;
            end
        end
        return m;
    endfunction

    localparam logic [NUM_INPUTS-1:0] COL_CONN = col_mask();
    localparam logic [NUM_OUTPUTS-1:0] ROW_CONN = row_mask();

    if (NUM_INPUTS < 1 || NUM_INPUTS > 256 ||
        NUM_OUTPUTS < 1 || NUM_OUTPUTS > 256) begin : g_bad_ports
        $fatal(1, "fabric_switch_buffered: port count out of range");
    end
    if (ROW_CONN != '1) begin : g_bad_row
        $fatal(1, "fabric_switch_buffered: empty CONNECTIVITY row");
    end
    if (COL_CONN != '1) begin : g_bad_col
        $fatal(1, "fabric_switch_buffered: empty CONNECTIVITY column");
    end
    if (FIFO_DEPTH < 1 || FIFO_DEPTH > 64) begin : g_bad_depth
        $fatal(1, "fabric_switch_buffered: FIFO_DEPTH out of range");
    end

    logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0] route;

    for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_row
        for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_col
            localparam int P = o * NUM_INPUTS + i;
            if (CONNECTIVITY[P]) begin : g_on
                assign route[o][i] = cfg_route_table[conn_before(P)];
            end else begin : g_off
                assign route[o][i] = 1'b0;
            end
        end
    end

    logic [NUM_INPUTS-1:0][NUM_OUTPUTS-1:0] sent;
    logic [NUM_OUTPUTS-1:0][IW-1:0]         rr_ptr;
    logic [NUM_OUTPUTS-1:0][CW-1:0]         count;
    logic [NUM_OUTPUTS-1:0][AW-1:0]         wr_ptr;
    logic [NUM_OUTPUTS-1:0][AW-1:0]         rd_ptr;
    logic [PAYLOAD_WIDTH-1:0]               mem [NUM_OUTPUTS][FIFO_DEPTH];

    logic [NUM_OUTPUTS-1:0]                 gnt_v;
    logic [NUM_OUTPUTS-1:0][IW-1:0]         gnt_idx;
    logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0] gnt_oh;
    logic [NUM_OUTPUTS-1:0]                 pop;
    logic [NUM_INPUTS-1:0]                  routed;
    logic [NUM_INPUTS-1:0]                  done;
    logic [NUM_INPUTS-1:0]                  retire;
    logic [NUM_OUTPUTS-1:0][PAYLOAD_WIDTH-1:0] head;
    logic [15:0]                            err_now;

    // A full FIFO is never grantable, so in_ready never looks at out_ready.
    always_comb begin
        int c;
        c = 0;
        gnt_v = '0;
        gnt_idx = '0;
        gnt_oh = '0;
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            if (rst_n && count[o] < CW'(FIFO_DEPTH)) begin
                for (int k = 0; k < NUM_INPUTS; k++) begin
                    c = int'(rr_ptr[o]) + k;
                    if (c >= NUM_INPUTS) c = c - NUM_INPUTS;
                    if (!gnt_v[o] && bus.in_valid[c] &&
                        route[o][c] && !sent[c][o]) begin
                        gnt_v[o] = 1'b1;
                        gnt_idx[o] = IW'(c);
                        gnt_oh[o][c] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        routed = '0;
        done = '1;
        retire = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            for (int o = 0; o < NUM_OUTPUTS; o++) begin
                if (route[o][i]) routed[i] = 1'b1;
                if (route[o][i] && !sent[i][o] && !gnt_oh[o][i]) begin
                    done[i] = 1'b0;
                end
            end
            retire[i] = bus.in_valid[i] && routed[i] && done[i];
        end
    end

    assign bus.in_ready = retire;

    always_comb begin
        pop = '0;
        head = '0;
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            if (count[o] != '0) begin
                pop[o] = bus.out_ready[o];
                head[o] = mem[o][rd_ptr[o]];
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            bus.out_valid[o] = (count[o] != '0);
        end
    end

    assign bus.out_data = head;

    function automatic logic [AW-1:0] ptr_inc(logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            rr_ptr <= '0;
        end else begin
            for (int o = 0; o < NUM_OUTPUTS; o++) begin
                if (gnt_v[o]) begin
                    wr_ptr[o] <= ptr_inc(wr_ptr[o]);
                    rr_ptr[o] <= (gnt_idx[o] == IW'(NUM_INPUTS - 1)) ?
                                 '0 : gnt_idx[o] + IW'(1);
                end
                if (pop[o]) rd_ptr[o] <= ptr_inc(rd_ptr[o]);
                count[o] <= count[o] + CW'(gnt_v[o]) - CW'(pop[o]);
            end
        end
    end

    // Storage is data-only; emptiness gating keeps stale entries off out_data.
    always_ff @(posedge clk) begin
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            if (gnt_v[o]) mem[o][wr_ptr[o]] <= bus.in_data[gnt_idx[o]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent <= '0;
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                for (int o = 0; o < NUM_OUTPUTS; o++) begin
                    sent[i][o] <= retire[i] ? 1'b0 : (sent[i][o] | gnt_oh[o][i]);
                end
            end
        end
    end

    always_comb begin
        logic cfg_err;
        logic rt_err;
        cfg_err = 1'b0;
        rt_err = 1'b0;
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            if (!ALLOW_MERGE && $countones(route[o]) > 1) cfg_err = 1'b1;
        end
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (bus.in_valid[i] && COL_CONN[i] && !routed[i]) rt_err = 1'b1;
        end
        err_now = cfg_err ? CFG_MIX_CODE :
                  rt_err  ? RT_UNROUTED_CODE : 16'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_valid <= 1'b0;
            error_code <= '0;
        end else if (!error_valid && err_now != '0) begin
            error_valid <= 1'b1;
            error_code <= err_now;
        end
    end

endmodule

// File: tb/tb_fabric_switch_buffered.sv
// Scoreboard bench for fabric_switch_buffered: random traffic against a
// queue-level reference model, plus directed error and depth-1 cases.
module tb_fabric_switch_buffered;

    localparam int NI = 4;
    localparam int NO = 4;
    localparam int PW = 32;
    localparam int DEPTH = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst_b_n;
    logic [NI*NO-1:0] cfg;
    logic [3:0] cfg_b;
    logic err_v;
    logic [15:0] err_c;
    logic err_v_b;
    logic [15:0] err_c_b;

    fabric_switch_buffered_if #(
        .NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .PAYLOAD_WIDTH(PW)
    ) bus_a ();

    fabric_switch_buffered_if #(
        .NUM_INPUTS(2), .NUM_OUTPUTS(2), .PAYLOAD_WIDTH(8)
    ) bus_b ();

    fabric_switch_buffered #(
        .NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .DATA_WIDTH(PW),
        .TAG_WIDTH(0), .CONNECTIVITY(16'hFFFF),
        .FIFO_DEPTH(DEPTH), .ALLOW_MERGE(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a),
        .cfg_route_table(cfg),
        .error_valid(err_v), .error_code(err_c)
    );

    fabric_switch_buffered #(
        .NUM_INPUTS(2), .NUM_OUTPUTS(2), .DATA_WIDTH(8),
        .TAG_WIDTH(0), .CONNECTIVITY(4'hF),
        .FIFO_DEPTH(1), .ALLOW_MERGE(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_b_n), .bus(bus_b),
        .cfg_route_table(cfg_b),
        .error_valid(err_v_b), .error_code(err_c_b)
    );

    int passed = 0;
    int total = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: occupancy per output, delivered-set per input,
    // round-robin start per output, expected output streams.
    bit route_m [NO][NI];
    bit sent_m [NI][NO];
    int rr_m [NO];
    int cnt_m [NO];
    int gnt_m [NO];
    bit rdy_m [NI];
    logic [PW-1:0] exp_q [NO][$];
    logic [31:0] tok = 32'h10;

    function automatic bit routed_m(int i);
        for (int o = 0; o < NO; o++) if (route_m[o][i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int o = 0; o < NO; o++) begin
            rr_m[o] = 0;
            cnt_m[o] = 0;
            gnt_m[o] = -1;
            exp_q[o].delete();
        end
        for (int i = 0; i < NI; i++) begin
            rdy_m[i] = 1'b0;
            for (int o = 0; o < NO; o++) sent_m[i][o] = 1'b0;
        end
    endtask

    task automatic set_cfg(logic [NI*NO-1:0] c);
        cfg = c;
        for (int o = 0; o < NO; o++)
            for (int i = 0; i < NI; i++) route_m[o][i] = c[o*NI+i];
    endtask

    task automatic drive(int pv, int pr, bit gen);
        for (int i = 0; i < NI; i++) begin
            if (!(bus_a.in_valid[i] && !rdy_m[i])) begin
                if (gen && routed_m(i) && $urandom_range(99) < pv) begin
                    bus_a.in_valid[i] = 1'b1;
                    bus_a.in_data[i] = tok;
                    tok++;
                end else begin
                    bus_a.in_valid[i] = 1'b0;
                    bus_a.in_data[i] = $urandom;
                end
            end
        end
        for (int o = 0; o < NO; o++)
            bus_a.out_ready[o] = ($urandom_range(99) < pr);
    endtask

    task automatic evaluate();
        for (int o = 0; o < NO; o++) begin
            gnt_m[o] = -1;
            if (cnt_m[o] < DEPTH) begin
                for (int k = 0; k < NI; k++) begin
                    int i;
                    i = (rr_m[o] + k) % NI;
                    if (gnt_m[o] < 0 && bus_a.in_valid[i] &&
                        route_m[o][i] && !sent_m[i][o]) gnt_m[o] = i;
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            bit all_held;
            all_held = 1'b1;
            for (int o = 0; o < NO; o++)
                if (route_m[o][i] && !sent_m[i][o] && gnt_m[o] != i) all_held = 1'b0;
            rdy_m[i] = bus_a.in_valid[i] && routed_m(i) && all_held;
            check($sformatf("in_ready[%0d]", i), 32'(bus_a.in_ready[i]), 32'(rdy_m[i]));
        end
        for (int o = 0; o < NO; o++) begin
            check($sformatf("out_valid[%0d]", o), 32'(bus_a.out_valid[o]), 32'(cnt_m[o] != 0));
            if (gnt_m[o] >= 0) exp_q[o].push_back(bus_a.in_data[gnt_m[o]]);
        end
    endtask

    task automatic commit();
        for (int o = 0; o < NO; o++) begin
            bit popped;
            popped = (cnt_m[o] > 0) && bus_a.out_ready[o];
            if (gnt_m[o] >= 0) begin
                cnt_m[o]++;
                rr_m[o] = (gnt_m[o] + 1) % NI;
            end
            if (popped) cnt_m[o]--;
        end
        for (int i = 0; i < NI; i++)
            for (int o = 0; o < NO; o++)
                sent_m[i][o] = rdy_m[i] ? 1'b0 : (sent_m[i][o] || gnt_m[o] == i);
    endtask

    task automatic cycle(int pv, int pr, bit gen);
        @(negedge clk);
        drive(pv, pr, gen);
        #1 evaluate();
        @(posedge clk);
        commit();
    endtask

    function automatic bit idle();
        for (int i = 0; i < NI; i++) begin
            if (bus_a.in_valid[i] && !rdy_m[i]) return 1'b0;
            for (int o = 0; o < NO; o++) if (sent_m[i][o]) return 1'b0;
        end
        for (int o = 0; o < NO; o++) if (cnt_m[o] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain();
        int budget;
        budget = 200;
        while (budget > 0 && !idle()) begin
            cycle(0, 100, 1'b0);
            budget--;
        end
        check("drain_idle", 32'(idle()), 32'd1);
    endtask

    // Monitor: pops the expected stream whenever an output head is taken.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            for (int o = 0; o < NO; o++) begin
                if (bus_a.out_valid[o] && bus_a.out_ready[o]) begin
                    if (exp_q[o].size() == 0) begin
                        total++;
                        $display("FAIL out_data[%0d] unexpected: got %0h expected none", o, bus_a.out_data[o]);
                    end else begin
                        check($sformatf("out_data[%0d]", o), bus_a.out_data[o], exp_q[o].pop_front());
                    end
                end
            end
        end
    end

    task automatic check_idle_outputs(string tag);
        for (int o = 0; o < NO; o++) begin
            check({tag, "_out_valid"}, 32'(bus_a.out_valid[o]), 32'd0);
            check({tag, "_out_data"}, bus_a.out_data[o], 32'd0);
        end
        check({tag, "_in_ready"}, 32'(bus_a.in_ready), 32'd0);
    endtask

    task automatic run_dut_b();
        rst_b_n = 1'b0;
        cfg_b = 4'b1001;
        bus_b.in_valid = '0;
        bus_b.in_data = '0;
        bus_b.out_ready = '0;
        @(negedge clk);
        check("b_reset_err_valid", 32'(err_v_b), 32'd0);
        check("b_reset_err_code", 32'(err_c_b), 32'd0);
        rst_b_n = 1'b1;
        bus_b.in_valid = 2'b01;
        bus_b.in_data[0] = 8'h5A;
        bus_b.out_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("b_depth1_in_ready", 32'(bus_b.in_ready[0]), 32'(k % 2 == 0));
            check("b_depth1_out_valid", 32'(bus_b.out_valid[0]), 32'(k % 2 == 1));
            if (k % 2 == 1) check("b_depth1_out_data", 32'(bus_b.out_data[0]), 32'h5A);
            @(negedge clk);
        end
        bus_b.in_valid = '0;
        cfg_b = 4'b0011;
        #1 check("b_mix_before_edge", 32'(err_v_b), 32'd0);
        @(negedge clk);
        check("b_mix_err_valid", 32'(err_v_b), 32'd1);
        check("b_mix_err_code", 32'(err_c_b), 32'd1);
        cfg_b = 4'b0001;
        bus_b.in_valid = 2'b10;
        @(negedge clk);
        check("b_sticky_code", 32'(err_c_b), 32'd1);
        rst_b_n = 1'b0;
        #1 check("b_rst_err_valid", 32'(err_v_b), 32'd0);
        @(negedge clk);
        rst_b_n = 1'b1;
        #1 check("b_unrouted_before_edge", 32'(err_v_b), 32'd0);
        @(negedge clk);
        check("b_unrouted_err_valid", 32'(err_v_b), 32'd1);
        check("b_unrouted_err_code", 32'(err_c_b), 32'd262);
    endtask

    initial begin
        rst_n = 1'b0;
        rst_b_n = 1'b0;
        cfg_b = '0;
        bus_b.in_valid = '0;
        bus_b.in_data = '0;
        bus_b.out_ready = '0;
        set_cfg('1);
        bus_a.in_valid = '1;
        bus_a.in_data = '0;
        bus_a.out_ready = '1;
        model_clear();
        repeat (2) @(negedge clk);
        #1 check_idle_outputs("reset");
        check("reset_err_valid", 32'(err_v), 32'd0);
        check("reset_err_code", 32'(err_c), 32'd0);
        bus_a.in_valid = '0;
        set_cfg(16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        set_cfg(16'h0010);
        repeat (12) cycle(100, 100, 1'b1);
        drain();

        set_cfg(16'h0011);
        repeat (40) cycle(100, 40, 1'b1);
        drain();

        set_cfg(16'h0007);
        repeat (30) cycle(100, 100, 1'b1);
        drain();

        set_cfg(16'h0100);
        repeat (6) cycle(100, 0, 1'b1);
        repeat (8) cycle(100, 100, 1'b1);
        drain();

        for (int r = 0; r < 8; r++) begin
            set_cfg(16'($urandom));
            repeat (150) cycle(60, 60, 1'b1);
            drain();
        end

        set_cfg(16'h3333);
        repeat (20) cycle(90, 30, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("midreset");
        bus_a.in_valid = '0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) cycle(70, 70, 1'b1);
        drain();

        check("final_err_valid", 32'(err_v), 32'd0);
        check("final_err_code", 32'(err_c), 32'd0);

        run_dut_b();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
